ctr_bank: RTL and testbench

Parametrised multi-channel up/down counter bank, the successor to the single 8-bit free-running `counter`. It provides NCH independent channels, each with enable, direction, synchronous load, a programmable terminal value, a wrap or saturate mode, a one-cycle terminal-count pulse and a sticky overflow flag. It sits beside the core as a timer/event-count resource and is driven directly by the bench or by a bus-register wrapper.

---
 rtl/ctr_pkg.sv | 18 +
 rtl/ctr_chan.sv | 72 +++++++
 rtl/ctr_bank.sv | 51 +++++
 tb/tb_ctr_bank.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ctr_pkg.sv
// ctr_pkg: shared definitions for the ctr_bank counter bank.
//   ctr_mode_e : boundary behaviour of a channel (wrap or saturate).
//   clamp_load : limits a load value to the terminal value.
package ctr_pkg;

    typedef enum logic {
        CTR_WRAP = 1'b0,
        CTR_SAT  = 1'b1
    } ctr_mode_e;

    // Operates on 32 bits so one function serves every legal WIDTH (2..32).
    // Callers zero-extend their operands and truncate the result.
    function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                               input logic [31:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/ctr_chan.sv
// ctr_chan: one up/down counter channel of ctr_bank.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   en        : count enable
//   dir       : 1 = count up, 0 = count down
//   ld        : synchronous load strobe (wins over en)
//   ld_val    : load value, clamped to MAX_VAL
//   clr_ovf   : clears the sticky overflow flag (a same-edge set wins)
//   q         : counter value (registered)
//   tc        : one-cycle pulse in the cycle after a boundary event
//   ovf       : sticky boundary-event flag
module ctr_chan
    import ctr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam ctr_mode_e MODE = ctr_mode_e'(SATURATE);

    logic [WIDTH-1:0] ld_clamped;

    assign ld_clamped = WIDTH'(clamp_load(32'(ld_val), 32'(MAX_VAL)));

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            tc <= 1'b0;
            // Cleared first so that a boundary event later in this block
            // overrides the clear on the same edge.
            if (clr_ovf) begin
                ovf <= 1'b0;
            end
            if (ld) begin
                q <= ld_clamped;
            end else if (en) begin
                if (dir) begin
                    if (q == MAX_VAL) begin
                        q   <= (MODE == CTR_SAT) ? MAX_VAL : '0;
                        tc  <= 1'b1;
                        ovf <= 1'b1;
                    end else begin
                        q <= q + WIDTH'(1);
                    end
                end else begin
                    if (q == '0) begin
                        q   <= (MODE == CTR_SAT) ? '0 : MAX_VAL;
                        tc  <= 1'b1;
                        ovf <= 1'b1;
                    end else begin
                        q <= q - WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ctr_bank.sv
// ctr_bank: NCH independent up/down counter channels.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   en        : [NCH] per-channel count enable
//   dir       : [NCH] per-channel direction, 1 = up
//   ld        : [NCH] per-channel synchronous load strobe
//   ld_val    : [NCH*WIDTH] load values, channel i at [i*WIDTH +: WIDTH]
//   clr_ovf   : [NCH] per-channel sticky-overflow clear
//   q         : [NCH*WIDTH] counter values, packed like ld_val
//   tc        : [NCH] one-cycle terminal-count pulses
//   ovf       : [NCH] sticky boundary-event flags
// All outputs come straight from channel flops.
module ctr_bank
    import ctr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      NCH      = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       dir,
    input  logic [NCH-1:0]       ld,
    input  logic [NCH*WIDTH-1:0] ld_val,
    input  logic [NCH-1:0]       clr_ovf,
    output logic [NCH*WIDTH-1:0] q,
    output logic [NCH-1:0]       tc,
    output logic [NCH-1:0]       ovf
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        ctr_chan #(
            .WIDTH    (WIDTH),
            .MAX_VAL  (MAX_VAL),
            .SATURATE (SATURATE)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .dir     (dir[i]),
            .ld      (ld[i]),
            .ld_val  (ld_val[i*WIDTH +: WIDTH]),
            .clr_ovf (clr_ovf[i]),
            .q       (q[i*WIDTH +: WIDTH]),
            .tc      (tc[i]),
            .ovf     (ovf[i])
        );
    end

endmodule

// File: tb/tb_ctr_bank.sv
// tb_ctr_bank: directed bench for ctr_bank (WIDTH=8, NCH=4, MAX_VAL=99).
// A wrapping and a saturating instance share the same stimulus.
module tb_ctr_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en, dir, ld, clr_ovf;
    logic [31:0] ld_val;
    logic [31:0] q_w, q_s;
    logic [3:0]  tc_w, tc_s, ovf_w, ovf_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctr_bank #(.WIDTH(8), .NCH(4), .MAX_VAL(8'd99), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .ld(ld), .ld_val(ld_val),
        .clr_ovf(clr_ovf), .q(q_w), .tc(tc_w), .ovf(ovf_w)
    );

    ctr_bank #(.WIDTH(8), .NCH(4), .MAX_VAL(8'd99), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .ld(ld), .ld_val(ld_val),
        .clr_ovf(clr_ovf), .q(q_s), .tc(tc_s), .ovf(ovf_s)
    );

    function automatic logic [31:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int qw[4], tw[4], qs[4], ts[4];

        // Reset held 3 cycles with every channel enabled.
        rst = 1'b1; en = 4'hF; dir = 4'hF; ld = 4'h0; clr_ovf = 4'h0; ld_val = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_q_w", q_w, 0);   chk("rst_q_s", q_s, 0);
            chk("rst_tc_w", 32'(tc_w), 0); chk("rst_ovf_w", 32'(ovf_w), 0);
            chk("rst_tc_s", 32'(tc_s), 0); chk("rst_ovf_s", 32'(ovf_s), 0);
        end

        // 50 up-counts after release: no terminal count reached.
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("run_tc_w", 32'(tc_w), 0); chk("run_tc_s", 32'(tc_s), 0);
        end
        chk("run50_q_w", q_w, pack4(50, 50, 50, 50));
        chk("run50_q_s", q_s, pack4(50, 50, 50, 50));

        // Wrap up on ch1 from 97.
        en = 4'h0; ld = 4'b0010; ld_val = pack4(0, 97, 0, 0);
        step();
        chk("ld97_q_w", 32'(q_w[15:8]), 97); chk("ld97_q_s", 32'(q_s[15:8]), 97);
        chk("ld97_tc_w", 32'(tc_w), 0);
        ld = 4'h0; en = 4'b0010;
        qw = '{98, 99, 0, 1};  tw = '{0, 0, 1, 0};
        qs = '{98, 99, 99, 99}; ts = '{0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wrapup_q_w", 32'(q_w[15:8]), 32'(qw[i])); chk("wrapup_tc_w", 32'(tc_w), 32'(tw[i] << 1));
            chk("wrapup_q_s", 32'(q_s[15:8]), 32'(qs[i])); chk("wrapup_tc_s", 32'(tc_s), 32'(ts[i] << 1));
        end
        chk("wrapup_ovf_w", 32'(ovf_w), 32'b0010); chk("wrapup_ovf_s", 32'(ovf_s), 32'b0010);

        // Clamped load and wrap down on ch2.
        en = 4'h0; ld = 4'b0100; ld_val = pack4(0, 0, 200, 0);
        step();
        chk("clamp_q_w", 32'(q_w[23:16]), 99); chk("clamp_q_s", 32'(q_s[23:16]), 99);
        chk("clamp_tc_w", 32'(tc_w), 0);       chk("clamp_ovf_w", 32'(ovf_w), 32'b0010);
        ld_val = pack4(0, 0, 1, 0);
        step();
        chk("ld1_q_w", 32'(q_w[23:16]), 1);
        ld = 4'h0; en = 4'b0100; dir = 4'b1011;
        qw = '{0, 99, 98, 0}; tw = '{0, 1, 0, 0};
        qs = '{0, 0, 0, 0};   ts = '{0, 1, 1, 0};
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wrapdn_q_w", 32'(q_w[23:16]), 32'(qw[i])); chk("wrapdn_tc_w", 32'(tc_w), 32'(tw[i] << 2));
            chk("wrapdn_q_s", 32'(q_s[23:16]), 32'(qs[i])); chk("wrapdn_tc_s", 32'(tc_s), 32'(ts[i] << 2));
        end

        // Saturate versus wrap at the top on ch0 from 98.
        en = 4'h0; dir = 4'hF; ld = 4'b0001; ld_val = pack4(98, 0, 0, 0);
        step();
        chk("ld98_q_s", 32'(q_s[7:0]), 98);
        ld = 4'h0; en = 4'b0001;
        qs = '{99, 99, 99, 0}; ts = '{0, 1, 1, 0};
        qw = '{99, 0, 1, 0};   tw = '{0, 1, 0, 0};
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sat_q_s", 32'(q_s[7:0]), 32'(qs[i])); chk("sat_tc_s", 32'(tc_s), 32'(ts[i]));
            chk("sat_q_w", 32'(q_w[7:0]), 32'(qw[i])); chk("sat_tc_w", 32'(tc_w), 32'(tw[i]));
        end

        // Load and enable together on ch3: load wins.
        ld = 4'b1000; en = 4'b1000; ld_val = pack4(0, 0, 0, 42);
        step();
        chk("ldvsen_q_w", 32'(q_w[31:24]), 42); chk("ldvsen_q_s", 32'(q_s[31:24]), 42);
        chk("ldvsen_tc_w", 32'(tc_w[3]), 0);

        // Boundary event with clr_ovf on the same edge: set wins.
        en = 4'h0; ld_val = pack4(0, 0, 0, 99);
        step();
        chk("ld99_q_w", 32'(q_w[31:24]), 99); chk("ld99_ovf_w", 32'(ovf_w[3]), 0);
        ld = 4'h0; en = 4'b1000; clr_ovf = 4'b1000;
        step();
        chk("setwin_ovf_w", 32'(ovf_w[3]), 1); chk("setwin_ovf_s", 32'(ovf_s[3]), 1);
        chk("setwin_tc_w", 32'(tc_w[3]), 1);   chk("setwin_q_w", 32'(q_w[31:24]), 0);
        chk("setwin_q_s", 32'(q_s[31:24]), 99);
        en = 4'h0;
        step();
        chk("clr_ovf_w", 32'(ovf_w[3]), 0); chk("clr_ovf_s", 32'(ovf_s[3]), 0);
        chk("clr_tc_w", 32'(tc_w[3]), 0);   chk("clr_ovf_w1", 32'(ovf_w[1]), 1);
        clr_ovf = 4'h0;

        // Mixed activity across channels, then reset mid-count.
        ld = 4'hF; ld_val = pack4(10, 20, 30, 60);
        step();
        chk("mix_ld_q_w", q_w, pack4(10, 20, 30, 60));
        ld = 4'h0; en = 4'b1011; dir = 4'b1010;
        step();
        chk("mix1_q_w", q_w, pack4(9, 21, 30, 61)); chk("mix1_q_s", q_s, pack4(9, 21, 30, 61));
        step();
        chk("mix2_q_w", q_w, pack4(8, 22, 30, 62)); chk("mix2_q_s", q_s, pack4(8, 22, 30, 62));
        rst = 1'b1; ld = 4'hF; clr_ovf = 4'hF;
        step();
        chk("midrst_q_w", q_w, 0);           chk("midrst_q_s", q_s, 0);
        chk("midrst_ovf_w", 32'(ovf_w), 0);  chk("midrst_ovf_s", 32'(ovf_s), 0);
        chk("midrst_tc_w", 32'(tc_w), 0);
        rst = 1'b0; ld = 4'h0; clr_ovf = 4'h0;
        step();
        chk("resume_q_w", q_w, pack4(99, 1, 0, 1)); chk("resume_q_s", q_s, pack4(0, 1, 0, 1));
        chk("resume_tc_w", 32'(tc_w), 32'b0001);    chk("resume_tc_s", 32'(tc_s), 32'b0001);
        chk("resume_ovf_w", 32'(ovf_w), 32'b0001);  chk("resume_ovf_s", 32'(ovf_s), 32'b0001);
        en = 4'h0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
